// File: rtl/blit_color_px.sv
// blit_color_px: colour stage of the blitter pipeline, between fetch (p3) and
// memory write (p4). Selects the source pixel from a memory word, uses a solid
// colour, or expands a 1-bpp glyph bit into foreground/background colour. It
// then applies colour-key or transparent-background drop and an optional
// raster op.
// Optional feature macro: BLIT_ROP_EN (raster ops against p3_dst_data).
// Without it the op is always SRC, and no ROP logic or dst pipeline register
// is built.
module blit_color_px #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p3_valid,
  output logic              p3_ready,
  input  logic [ADDR_W-1:0] p3_dst_address,
  input  logic [ADDR_W-1:0] p3_src_address,
  input  logic [DATA_W-1:0] p3_data,
  input  logic [PIX_W-1:0]  p3_dst_data,
  input  logic              p3_is_mem,
  input  logic              p3_is_text,
  input  logic [2:0]        p3_bit_index,
  input  logic [PIX_W-1:0]  reg_color,
  input  logic [PIX_W-1:0]  reg_bgcolor,
  input  logic              reg_bg_transparent,
  input  logic              reg_key_en,
  input  logic [PIX_W-1:0]  reg_key,
  input  logic [1:0]        reg_rop,
  output logic              p4_valid,
  input  logic              p4_ready,
  output logic [ADDR_W-1:0] p4_address,
  output logic [PIX_W-1:0]  p4_wdata
);

  // Handshake: a beat moves on valid & ready at a rising clock edge on either
  // side. The O stage (p4 outputs) advances when p4_ready is high or O is
  // empty. X advances when O advances or X is empty, and p3_ready is exactly
  // that X-advance condition. While p4_valid=1 and p4_ready=0, O holds and its
  // outputs stay stable. A dropped beat still advances out of X, but it does
  // not fill O.

  logic              x_valid;
  logic [ADDR_W-1:0] x_dst_address;
  logic [1:0]        x_lane;
  logic [DATA_W-1:0] x_data;
  logic              x_is_mem;
  logic              x_is_text;
  logic [2:0]        x_bit_index;
`ifdef BLIT_ROP_EN
  logic [PIX_W-1:0]  x_dst_data;
`endif

  logic              o_adv;
  logic              x_adv;
  logic [7:0]        mem_byte;
  logic [7:0]        glyph_byte;
  logic              glyph_bit;
  logic [PIX_W-1:0]  lane_pix;
  logic [PIX_W-1:0]  copy_pix;
  logic [PIX_W-1:0]  src_pix;
  logic [PIX_W-1:0]  final_pix;
  logic              drop;

  assign o_adv    = p4_ready | ~p4_valid;
  assign x_adv    = o_adv | ~x_valid;
  assign p3_ready = x_adv;

  // Only the low two source address bits pick a lane; the rest are don't-care.
`ifdef BLIT_ROP_EN
  logic unused_bits;
  assign unused_bits = ^p3_src_address[ADDR_W-1:2];
`else
  logic unused_bits;
  assign unused_bits = ^{p3_src_address[ADDR_W-1:2], reg_rop, p3_dst_data};
`endif

  // Byte lane of the captured memory word; also the glyph byte source.
  always_comb begin
    mem_byte = x_data[7:0];
    case (x_lane)
      2'd0:    mem_byte = x_data[7:0];
      2'd1:    mem_byte = x_data[15:8];
      2'd2:    mem_byte = x_data[23:16];
      default: mem_byte = x_data[31:24];
    endcase
  end

  // Pixel-width lane select: a halfword lane ignores address bit 0.
  generate
    if (PIX_W == 16) begin : g_pix16
      assign lane_pix = x_lane[1] ? x_data[31:16] : x_data[15:0];
    end else begin : g_pix8
      assign lane_pix = mem_byte;
    end
  endgenerate

  // Source pixel, glyph expansion and drop decision for the beat in X.
  always_comb begin
    glyph_byte = x_is_mem ? mem_byte : x_data[7:0];
    glyph_bit  = glyph_byte[3'd7 - x_bit_index];
    copy_pix   = x_is_mem ? lane_pix : x_data[PIX_W-1:0];
    src_pix    = copy_pix;
    drop       = 1'b0;
    if (x_is_text) begin
      src_pix = glyph_bit ? reg_color : reg_bgcolor;
      drop    = ~glyph_bit & reg_bg_transparent;
    end else begin
      drop    = reg_key_en & x_is_mem & (copy_pix == reg_key);
    end
  end

`ifdef BLIT_ROP_EN
  // Raster op of the final pixel against the destination pixel of the beat.
  always_comb begin
    final_pix = src_pix;
    case (reg_rop)
      2'd1:    final_pix = src_pix & x_dst_data;
      2'd2:    final_pix = src_pix | x_dst_data;
      2'd3:    final_pix = src_pix ^ x_dst_data;
      default: final_pix = src_pix;
    endcase
  end
`else
  assign final_pix = src_pix;
`endif

  // Stage X: capture the incoming p3 beat whenever X may advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_valid       <= 1'b0;
      x_dst_address <= '0;
      x_lane        <= '0;
      x_data        <= '0;
      x_is_mem      <= 1'b0;
      x_is_text     <= 1'b0;
      x_bit_index   <= '0;
`ifdef BLIT_ROP_EN
      x_dst_data    <= '0;
`endif
    end else if (x_adv) begin
      x_valid <= p3_valid;
      if (p3_valid) begin
        x_dst_address <= p3_dst_address;
        x_lane        <= p3_src_address[1:0];
        x_data        <= p3_data;
        x_is_mem      <= p3_is_mem;
        x_is_text     <= p3_is_text;
        x_bit_index   <= p3_bit_index;
`ifdef BLIT_ROP_EN
        x_dst_data    <= p3_dst_data;
`endif
      end
    end
  end

  // Stage O: load surviving beats from X; dropped beats leave O empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p4_valid   <= 1'b0;
      p4_address <= '0;
      p4_wdata   <= '0;
    end else if (o_adv) begin
      p4_valid <= x_valid & ~drop;
      if (x_valid && !drop) begin
        p4_address <= x_dst_address;
        p4_wdata   <= final_pix;
      end
    end
  end

endmodule

// File: tb/tb_blit_color_px.sv
// tb_blit_color_px: directed bench for blit_color_px. An 8-bpp instance covers
// copy, text, drop, ROP, backpressure and reset; a 16-bpp instance covers
// halfword lane selection.
module tb_blit_color_px;

  localparam int AW = 26;
  localparam int PW = 8;
  localparam int EW = AW + PW;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- 8-bpp DUT signals ----------------
  logic          p3_valid;
  logic          p3_ready;
  logic [AW-1:0] p3_dst_address;
  logic [AW-1:0] p3_src_address;
  logic [31:0]   p3_data;
  logic [PW-1:0] p3_dst_data;
  logic          p3_is_mem;
  logic          p3_is_text;
  logic [2:0]    p3_bit_index;
  logic [PW-1:0] reg_color;
  logic [PW-1:0] reg_bgcolor;
  logic          reg_bg_transparent;
  logic          reg_key_en;
  logic [PW-1:0] reg_key;
  logic [1:0]    reg_rop;
  logic          p4_valid;
  logic          p4_ready;
  logic [AW-1:0] p4_address;
  logic [PW-1:0] p4_wdata;

  blit_color_px #(.ADDR_W(AW), .DATA_W(32), .PIX_W(PW)) dut (
    .clock(clock), .reset(reset),
    .p3_valid(p3_valid), .p3_ready(p3_ready),
    .p3_dst_address(p3_dst_address), .p3_src_address(p3_src_address),
    .p3_data(p3_data), .p3_dst_data(p3_dst_data),
    .p3_is_mem(p3_is_mem), .p3_is_text(p3_is_text), .p3_bit_index(p3_bit_index),
    .reg_color(reg_color), .reg_bgcolor(reg_bgcolor),
    .reg_bg_transparent(reg_bg_transparent), .reg_key_en(reg_key_en),
    .reg_key(reg_key), .reg_rop(reg_rop),
    .p4_valid(p4_valid), .p4_ready(p4_ready),
    .p4_address(p4_address), .p4_wdata(p4_wdata)
  );

  // ---------------- 16-bpp DUT signals ----------------
  logic          q_p3_valid;
  logic          q_p3_ready;
  logic [AW-1:0] q_src_address;
  logic [31:0]   q_data;
  logic [15:0]   q_zero16;
  logic          q_p4_valid;
  logic          q_p4_ready;
  logic [AW-1:0] q_p4_address;
  logic [15:0]   q_p4_wdata;

  blit_color_px #(.ADDR_W(AW), .DATA_W(32), .PIX_W(16)) dut16 (
    .clock(clock), .reset(reset),
    .p3_valid(q_p3_valid), .p3_ready(q_p3_ready),
    .p3_dst_address(26'h0000040), .p3_src_address(q_src_address),
    .p3_data(q_data), .p3_dst_data(q_zero16),
    .p3_is_mem(1'b1), .p3_is_text(1'b0), .p3_bit_index(3'd0),
    .reg_color(q_zero16), .reg_bgcolor(q_zero16),
    .reg_bg_transparent(1'b0), .reg_key_en(1'b0),
    .reg_key(q_zero16), .reg_rop(2'd0),
    .p4_valid(q_p4_valid), .p4_ready(q_p4_ready),
    .p4_address(q_p4_address), .p4_wdata(q_p4_wdata)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks;
  int failures;
  int rx_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_px(input logic [AW-1:0] a, input logic [PW-1:0] p);
    exp_q.push_back({a, p});
  endtask

  // Every p4 handshake is popped against the expected queue, in order.
  always @(negedge clock) begin
    if (!reset && p4_valid && p4_ready) begin
      rx_count++;
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("p4_address", p4_address, mon_e[EW-1:PW]);
        check("p4_wdata", p4_wdata, mon_e[PW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat at posedge+1, wait (bounded) for p3_ready sampled at the
  // falling edge, then retire it one edge later.
  task automatic send(input logic [AW-1:0] dst, input logic [AW-1:0] src,
                      input logic [31:0] data, input logic is_mem,
                      input logic is_text, input logic [2:0] bi,
                      input logic [PW-1:0] dd, output int waits);
    p3_dst_address = dst;
    p3_src_address = src;
    p3_data        = data;
    p3_is_mem      = is_mem;
    p3_is_text     = is_text;
    p3_bit_index   = bi;
    p3_dst_data    = dd;
    p3_valid       = 1'b1;
    waits = 0;
    @(negedge clock);
    while (!p3_ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    if (waits >= 50) check("p3_ready_timeout", waits, 0);
    @(posedge clock);
    #1;
    p3_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || p4_valid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic send16(input string tag, input logic [AW-1:0] src, input logic [15:0] exp);
    q_src_address = src;
    q_data        = 32'hA1B2C3D4;
    q_p3_valid    = 1'b1;
    @(negedge clock);
    check("w16_p3_ready", q_p3_ready, 1);
    @(posedge clock);
    #1;
    q_p3_valid = 1'b0;
    @(posedge clock);
    #1;
    check("w16_p4_valid", q_p4_valid, 1);
    check(tag, q_p4_wdata, exp);
    check("w16_p4_address", q_p4_address, 26'h40);
    @(posedge clock);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  localparam logic [7:0] ROP_EXP [4] = '{
`ifdef BLIT_ROP_EN
    8'hF0, 8'h30, 8'hFC, 8'hCC
`else
    8'hF0, 8'hF0, 8'hF0, 8'hF0
`endif
  };

  initial begin
    int w;
    int rx_before;
    checks = 0; failures = 0; rx_count = 0;
    reset = 1'b1;
    p3_valid = 1'b0; p3_dst_address = '0; p3_src_address = '0; p3_data = '0;
    p3_dst_data = '0; p3_is_mem = 1'b0; p3_is_text = 1'b0; p3_bit_index = '0;
    reg_color = '0; reg_bgcolor = '0; reg_bg_transparent = 1'b0;
    reg_key_en = 1'b0; reg_key = '0; reg_rop = 2'd0; p4_ready = 1'b0;
    q_p3_valid = 1'b0; q_src_address = '0; q_data = '0; q_zero16 = '0; q_p4_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_p4_valid", p4_valid, 0);
    check("rst_p4_address", p4_address, 0);
    check("rst_p4_wdata", p4_wdata, 0);
    reset = 1'b0;
    #1;
    check("rst_p3_ready", p3_ready, 1);
    @(posedge clock);
    #1;
    p4_ready = 1'b1;

    // 16-bpp halfword lanes: bit1 selects, bit0 ignored
    send16("w16_hi", 26'h0000002, 16'hA1B2);
    send16("w16_lo", 26'h0000001, 16'hC3D4);

    // Copy 8-bpp lane 2, with high source bits set; check 2-cycle latency
    expect_px(26'h0000100, 8'hB2);
    send(26'h0000100, 26'h3FFF002, 32'hA1B2C3D4, 1'b1, 1'b0, 3'd0, 8'h00, w);
    check("lat_not_yet", p4_valid, 0);
    @(posedge clock);
    #1;
    check("lat_valid", p4_valid, 1);
    check("lat_wdata", p4_wdata, 8'hB2);
    drain();

    // Other lanes and solid colour
    expect_px(26'h0000101, 8'hD4);
    send(26'h0000101, 26'h0000000, 32'hA1B2C3D4, 1'b1, 1'b0, 3'd0, 8'h00, w);
    expect_px(26'h0000102, 8'hA1);
    send(26'h0000102, 26'h0000003, 32'hA1B2C3D4, 1'b1, 1'b0, 3'd0, 8'h00, w);
    expect_px(26'h0000103, 8'h77);
    send(26'h0000103, 26'h0000002, 32'hA1B2C377, 1'b0, 1'b0, 3'd0, 8'h00, w);
    drain();

    // Text expansion: glyph 0x81 in lane 1
    reg_color = 8'h0F; reg_bgcolor = 8'h20;
    expect_px(26'h0000200, 8'h0F);
    send(26'h0000200, 26'h0000001, 32'h00008100, 1'b1, 1'b1, 3'd0, 8'h00, w);
    expect_px(26'h0000201, 8'h20);
    send(26'h0000201, 26'h0000001, 32'h00008100, 1'b1, 1'b1, 3'd1, 8'h00, w);
    expect_px(26'h0000202, 8'h0F);
    send(26'h0000202, 26'h0000001, 32'h00008100, 1'b1, 1'b1, 3'd7, 8'h00, w);
    expect_px(26'h0000203, 8'h0F);
    send(26'h0000203, 26'h0000003, 32'hFFFFFF81, 1'b0, 1'b1, 3'd7, 8'h00, w);
    drain();

    // Transparent background: bit 0 dropped, next beat emerges in order
    reg_bg_transparent = 1'b1;
    rx_before = rx_count;
    send(26'h0000210, 26'h0000001, 32'h00008100, 1'b1, 1'b1, 3'd1, 8'h00, w);
    expect_px(26'h0000211, 8'h0F);
    send(26'h0000211, 26'h0000001, 32'h00008100, 1'b1, 1'b1, 3'd0, 8'h00, w);
    drain();
    check("transp_beats", rx_count - rx_before, 1);
    reg_bg_transparent = 1'b0;

    // Colour key: 0x55 dropped, 0x12 kept; solid 0x55 is not keyed
    reg_key_en = 1'b1; reg_key = 8'h55;
    rx_before = rx_count;
    send(26'h0000300, 26'h0000000, 32'h00000055, 1'b1, 1'b0, 3'd0, 8'h00, w);
    check("key_ready_0", w, 0);
    expect_px(26'h0000301, 8'h12);
    send(26'h0000301, 26'h0000000, 32'h00000012, 1'b1, 1'b0, 3'd0, 8'h00, w);
    check("key_ready_1", w, 0);
    expect_px(26'h0000302, 8'h55);
    send(26'h0000302, 26'h0000000, 32'h00000055, 1'b0, 1'b0, 3'd0, 8'h00, w);
    check("key_ready_2", w, 0);
    drain();
    check("key_beats", rx_count - rx_before, 2);
    reg_key_en = 1'b0;

    // Raster ops: pixel 0xF0 against dst 0x3C
    for (int r = 0; r < 4; r++) begin
      reg_rop = r[1:0];
      expect_px(26'h0000400 + AW'(r), ROP_EXP[r]);
      send(26'h0000400 + AW'(r), 26'h0, 32'h000000F0, 1'b0, 1'b0, 3'd0, 8'h3C, w);
      drain();
    end
    reg_rop = 2'd0;

    // Backpressure: 4 beats, output stalled for 5 cycles
    rx_before = rx_count;
    for (int i = 0; i < 4; i++) expect_px(26'h0000500 + AW'(i), 8'hA0 + 8'(i));
    send(26'h0000500, 26'h0, 32'h000000A0, 1'b0, 1'b0, 3'd0, 8'h00, w);
    send(26'h0000501, 26'h0, 32'h000000A1, 1'b0, 1'b0, 3'd0, 8'h00, w);
    p4_ready = 1'b0;
    fork
      begin
        send(26'h0000502, 26'h0, 32'h000000A2, 1'b0, 1'b0, 3'd0, 8'h00, w);
        send(26'h0000503, 26'h0, 32'h000000A3, 1'b0, 1'b0, 3'd0, 8'h00, w);
      end
      begin
        repeat (5) begin
          @(negedge clock);
          check("bp_p3_ready", p3_ready, 0);
          check("bp_p4_valid", p4_valid, 1);
          check("bp_hold_wdata", p4_wdata, 8'hA0);
          check("bp_hold_addr", p4_address, 26'h500);
        end
        @(posedge clock);
        #1;
        p4_ready = 1'b1;
      end
    join
    drain();
    check("bp_beats", rx_count - rx_before, 4);

    // Reset during a stall discards in-flight beats
    expect_px(26'h0000600, 8'h11);
    send(26'h0000600, 26'h0, 32'h00000011, 1'b0, 1'b0, 3'd0, 8'h00, w);
    expect_px(26'h0000601, 8'h22);
    send(26'h0000601, 26'h0, 32'h00000022, 1'b0, 1'b0, 3'd0, 8'h00, w);
    p4_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("stall_p4_valid", p4_valid, 1);
    reset = 1'b1;
    #1;
    check("midrst_p4_valid", p4_valid, 0);
    check("midrst_p4_wdata", p4_wdata, 0);
    check("midrst_p4_address", p4_address, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("postrst_p3_ready", p3_ready, 1);
    p4_ready = 1'b1;
    rx_before = rx_count;
    repeat (5) @(posedge clock);
    #1;
    check("postrst_no_stale", rx_count - rx_before, 0);
    check("postrst_p4_valid", p4_valid, 0);
    expect_px(26'h0000700, 8'h5A);
    send(26'h0000700, 26'h0000000, 32'h0000005A, 1'b1, 1'b0, 3'd0, 8'h00, w);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blit_color_px.md
Name: blit_color_px

Overview:
- Parametrised colour stage of the blitter pipeline. Sits between the read/fetch stage (p3) and the memory write stage (p4).
- Extracts the source pixel from a memory word, or uses a solid colour. Expands 1-bpp text glyph bits into foreground/background colour.
- Supports colour-key and transparent-background drop, optional raster ops, and 8- or 16-bpp pixels.
- Full valid/ready backpressure on both sides, so the p4 write port can stall the blitter.

Parameters:
- ADDR_W, 26: byte address width of src/dst addresses.
- DATA_W, 32: memory read word width; must be 32.
- PIX_W, 8: pixel width in bits; legal values 8 or 16.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p3_valid  in  1  input beat valid
- p3_ready  out  1  stage can accept an input beat this cycle
- p3_dst_address  in  ADDR_W  destination byte address
- p3_src_address  in  ADDR_W  source byte address; low bits select the lane
- p3_data  in  DATA_W  memory word, or solid colour in [PIX_W-1:0]
- p3_dst_data  in  PIX_W  current destination pixel (used for ROP only)
- p3_is_mem  in  1  1 = pixel from memory lane, 0 = solid colour
- p3_is_text  in  1  1 = glyph expand mode
- p3_bit_index  in  3  glyph bit index (bit 7-index of selected byte)
- reg_color  in  PIX_W  text foreground colour
- reg_bgcolor  in  PIX_W  text background colour
- reg_bg_transparent  in  1  drop text pixels whose glyph bit is 0
- reg_key_en  in  1  enable colour-key drop in copy mode
- reg_key  in  PIX_W  colour key value
- reg_rop  in  2  raster op: 0 = SRC, 1 = AND, 2 = OR, 3 = XOR
- p4_valid  out  1  output write beat valid
- p4_ready  in  1  write stage accepts the beat
- p4_address  out  ADDR_W  write address
- p4_wdata  out  PIX_W  pixel to write

Behaviour:
- Two registered stages, X then O.
  - X captures p3 fields.
  - O holds the p4 outputs.
- Latency: 2 cycles from p3 accept to p4_valid when no stall.
- Handshake:
  - O advances when p4_ready=1 or O is empty.
  - X advances when O advances or X is empty.
  - p3_ready equals the X-advance condition.
  - A beat transfers on p3_valid & p3_ready and on p4_valid & p4_ready.
  - Outputs hold stable while p4_valid=1 and p4_ready=0.
- Lane select (stage X output):
  - PIX_W=8: byte lane = src_address[1:0].
  - PIX_W=16: halfword lane = src_address[1]; src_address[0] is ignored.
  - When is_mem=0, the pixel is data[PIX_W-1:0].
- Text mode:
  - The glyph byte is always the 8-bit lane selected by src_address[1:0] (or data[7:0] when is_mem=0).
  - bit = glyph[7-bit_index].
  - pixel = bit ? reg_color : reg_bgcolor.
- Drop rules (no p4 beat is produced; the input beat is still consumed):
  - Text mode, bit=0, and reg_bg_transparent=1.
  - Non-text mode, reg_key_en=1, is_mem=1, and the selected pixel equals reg_key.
- Ordering: drops never reorder beats; surviving beats emerge in input order.
- ROP: applied to the final pixel against p3_dst_data captured with the beat.
  - SRC: pixel
  - AND: pixel & dst
  - OR: pixel | dst
  - XOR: pixel ^ dst
- Register sampling: reg_* inputs are sampled when X transfers to O. Software changes them only while the blitter is idle.
- Reset (asynchronous, any time, including mid-stall):
  - X valid, O valid and p4_valid clear to 0.
  - p4_address and p4_wdata clear to 0.
  - p3_ready is 1 in the first cycle after reset deasserts.
  - In-flight beats are discarded.
- Simultaneous O output and X input in one cycle is allowed; full throughput is 1 beat/cycle.
- Unused high src_address bits are ignored.

Optional Feature:
- Macro: BLIT_ROP_EN
- Defined: reg_rop and p3_dst_data are honoured as described in Behaviour.
- Undefined:
  - reg_rop and p3_dst_data are ignored; the op is always SRC.
  - The ROP logic and the dst_data pipeline register are not built.

Test Plan:
- Copy, PIX_W=8: data=0xA1B2C3D4, src_address[1:0]=2, p4_ready=1 -> p4_wdata=0xB2 two cycles later, p4_address=dst.
- Copy, PIX_W=16: data=0xA1B2C3D4, src_address[1]=1 -> p4_wdata=0xA1B2; with src_address[1]=0 -> 0xC3D4.
- Text:
  - glyph 0x81, bit_index=0, color=0x0F, bg=0x20 -> 0x0F.
  - bit_index=1 -> 0x20.
  - bit_index=1 with reg_bg_transparent=1 -> no p4 beat; the following beat emerges next in order.
- Colour key: reg_key_en=1, key=0x55, stream of pixels 0x55,0x12 -> only 0x12 written; p3_ready stays 1.
- Backpressure:
  - Feed 4 beats at 1/cycle; hold p4_ready=0 from cycle 3 for 5 cycles.
  - Required: p3_ready drops; outputs stay stable; all 4 beats emerge in order after release, none lost or duplicated.
  - Assert reset during the stall -> p4_valid=0 immediately and no stale beat after reset.
- BLIT_ROP_EN defined: pixel 0xF0 with dst 0x3C -> AND gives 0x30, OR gives 0xFC, XOR gives 0xCC. Undefined: same stimulus gives 0xF0 for every rop.
